// File: rtl/riscv_data_arbiter.sv
// rtl/riscv_data_arbiter.sv - round-robin data bus arbiter with bounded lock and read-data return
module riscv_data_arbiter #(
    parameter int XLEN     = 32,
    parameter int NMASTERS = 2,
    parameter int MAX_LOCK = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NMASTERS-1:0]                  m_req,
    input  logic [NMASTERS-1:0]                  m_lock,
    input  logic [NMASTERS-1:0]                  m_we,
    input  logic [NMASTERS-1:0][XLEN/8-1:0]      m_be,
    input  logic [NMASTERS-1:0][XLEN-1:0]        m_addr,
    input  logic [NMASTERS-1:0][XLEN-1:0]        m_wdata,
    output logic [NMASTERS-1:0]                  m_gnt,
    output logic [NMASTERS-1:0]                  m_done,
    output logic [XLEN-1:0]                      m_rdata,
    output logic                                 s_req,
    output logic                                 s_we,
    output logic [XLEN/8-1:0]                    s_be,
    output logic [XLEN-1:0]                      s_addr,
    output logic [XLEN-1:0]                      s_wdata,
    input  logic [XLEN-1:0]                      s_rdata
);

    localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic [IW-1:0] last_idx;
    logic          lock_act;
    logic [IW-1:0] lock_own;
    logic [CW-1:0] lock_cnt;
    logic          resp_vld;
    logic [IW-1:0] resp_idx;

    logic          lock_hold;
    logic          gnt_any;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand_idx;
    int            cand;
    logic          gnt_locked;
    logic [CW-1:0] cnt_next;
    logic [IW-1:0] sel;

    // The lock owner keeps the bus only while it still asks for both req and lock
    assign lock_hold = lock_act && m_req[lock_own] && m_lock[lock_own];

    // Pick the winner: lock owner first, otherwise first requester after last_idx
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        if (!rst) begin
            if (lock_hold) begin
                gnt_any = 1'b1;
                gnt_idx = lock_own;
            end else begin
                for (int k = 1; k <= NMASTERS; k++) begin
                    cand = int'(last_idx) + k;
                    if (cand >= NMASTERS) cand = cand - NMASTERS;
                    cand_idx = IW'(cand);
                    if (!gnt_any && m_req[cand_idx]) begin
                        gnt_any = 1'b1;
                        gnt_idx = cand_idx;
                    end
                end
            end
        end
    end

    assign m_gnt      = gnt_any ? (NMASTERS'(1) << gnt_idx) : '0;
    assign gnt_locked = gnt_any && m_lock[gnt_idx];
    // A locked grant to the current owner extends the run; any other locked grant starts one
    assign cnt_next   = (lock_act && (lock_own == gnt_idx)) ? lock_cnt + CW'(1) : CW'(1);

    // Slave side follows the winner; with no winner it idles on master 0's fields
    assign sel     = gnt_any ? gnt_idx : '0;
    assign s_req   = gnt_any;
    assign s_we    = m_we[sel];
    assign s_be    = m_be[sel];
    assign s_addr  = m_addr[sel];
    assign s_wdata = m_wdata[sel];

    // Response of last cycle's grant; suppressed while reset is asserted
    assign m_done  = (resp_vld && !rst) ? (NMASTERS'(1) << resp_idx) : '0;
    assign m_rdata = s_rdata;

    // Round-robin pointer, lock bookkeeping and response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx <= IW'(NMASTERS - 1);
            lock_act <= 1'b0;
            lock_own <= '0;
            lock_cnt <= '0;
            resp_vld <= 1'b0;
            resp_idx <= '0;
        end else begin
            resp_vld <= gnt_any;
            resp_idx <= gnt_idx;
            if (gnt_any) begin
                last_idx <= gnt_idx;
                if (gnt_locked) begin
                    if (cnt_next == CW'(MAX_LOCK)) begin
                        lock_act <= 1'b0;
                        lock_cnt <= '0;
                    end else begin
                        lock_act <= 1'b1;
                        lock_own <= gnt_idx;
                        lock_cnt <= cnt_next;
                    end
                end else begin
                    lock_act <= 1'b0;
                    lock_cnt <= '0;
                end
            end else begin
                lock_act <= 1'b0;
            end
        end
    end

endmodule
